// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Converts the read side of a FIFO (rdata/rempty/rinc) into a valid/ready
// stream. A 2-entry register buffer (head, tail) sits between the FIFO and
// the stream. Because the pop strobe depends only on the buffer occupancy,
// there is no combinational path from m_tready back to rinc.
//
// Ports
//   clk      : clock, shared with the FIFO read clock
//   reset    : asynchronous, active-high reset
//   rdata    : FIFO read data, valid whenever rempty is low
//   rempty   : FIFO empty flag
//   rinc     : FIFO pop strobe, one word consumed per cycle it is high
//   m_tvalid : stream data valid (buffer not empty)
//   m_tready : stream ready
//   m_tdata  : stream data (head entry)
//   count    : words currently held in the buffer (0..2)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DSIZE-1:0] m_tdata,
  output logic [1:0]       count
);

  logic [1:0]       cnt_p0;
  logic [1:0]       cnt_nxt;
  logic [DSIZE-1:0] head_p0;
  logic [DSIZE-1:0] tail_p0;
  logic             full;
  logic             push;
  logic             pop;

  assign full = (cnt_p0 == 2'(DEPTH));

  // Reset gates rinc directly so no word is consumed while the buffer is
  // held empty; the FIFO itself is also in reset during that time.
  assign rinc     = !rempty && !full && !reset;
  assign push     = rinc;
  assign pop      = m_tvalid && m_tready;
  assign m_tvalid = (cnt_p0 != 2'd0);
  assign m_tdata  = head_p0;
  assign count    = cnt_p0;

  always_comb begin
    cnt_nxt = cnt_p0;
    if (push && !pop) begin
      cnt_nxt = cnt_p0 + 2'd1;
    end else if (pop && !push) begin
      cnt_nxt = cnt_p0 - 2'd1;
    end
  end

  // Stage p0: occupancy (control, reset) and buffer entries (data, no reset)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0 <= 2'd0;
    end else begin
      cnt_p0 <= cnt_nxt;
    end
  end

  // Head takes the incoming word when the buffer is, or is about to become,
  // empty of older words; otherwise the tail shifts forward on a pop.
  // A push while full cannot happen because rinc is gated by full.
  always_ff @(posedge clk) begin
    if (push && ((cnt_p0 == 2'd0) || ((cnt_p0 == 2'd1) && pop))) begin
      head_p0 <= rdata;
    end else if (pop && (cnt_p0 == 2'd2)) begin
      head_p0 <= tail_p0;
    end
    if (push && (cnt_p0 == 2'd1) && !pop) begin
      tail_p0 <= rdata;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Bench for fifo_rd_stream. The FIFO is modelled as a queue of words, the
// output buffer as a queue of at most two words; every cycle the DUT
// outputs are compared against what those queues imply.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       rempty = 1'b1;
  logic       m_tready = 1'b0;
  logic       rinc;
  logic       m_tvalid;
  logic [7:0] m_tdata;
  logic [1:0] count;

  fifo_rd_stream #(.DSIZE(8), .DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .count    (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  logic [7:0] src_q[$];
  logic [7:0] out_q[$];
  logic [7:0] got_q[$];
  int         recv_cnt = 0;

  logic       obs_rinc;
  logic       obs_valid;
  logic [7:0] obs_tdata;
  logic [1:0] obs_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs with
  // the model, then advance the model by what the next rising edge does.
  task automatic step(input bit rdy, input bit gap);
    bit exp_rinc;
    bit pop;
    @(negedge clk);
    m_tready = rdy;
    rempty   = gap || (src_q.size() == 0);
    rdata    = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
    #1;
    obs_rinc  = rinc;
    obs_valid = m_tvalid;
    obs_tdata = m_tdata;
    obs_count = count;
    exp_rinc = !rempty && (out_q.size() < 2) && !reset;
    chk("rinc", 32'(rinc), 32'(exp_rinc));
    chk("m_tvalid", 32'(m_tvalid), 32'(out_q.size() != 0));
    chk("count", 32'(count), 32'(out_q.size()));
    if (out_q.size() != 0) chk("m_tdata", 32'(m_tdata), 32'(out_q[0]));
    if (reset) begin
      out_q.delete();
      src_q.delete();
    end
    pop = (out_q.size() != 0) && rdy && !reset;
    if (pop) begin
      got_q.push_back(out_q.pop_front());
      recv_cnt++;
    end
    if (exp_rinc) out_q.push_back(src_q.pop_front());
  endtask

  initial begin
    int pulses;
    int peak;
    logic [7:0] w;
    logic [7:0] exp5[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] exp3[3] = '{8'hC1, 8'hC2, 8'hC3};

    // Asynchronous reset at power-up, with rempty low so rinc gating shows.
    #1 reset = 1'b1;
    rempty = 1'b0;
    #1;
    chk("por_count", 32'(count), 32'd0);
    chk("por_valid", 32'(m_tvalid), 32'd0);
    chk("por_rinc", 32'(rinc), 32'd0);
    repeat (3) step(1'b1, 1'b1);
    reset = 1'b0;

    // Idle: FIFO empty for 10 cycles.
    repeat (10) step(1'b1, 1'b1);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_valid", 32'(m_tvalid), 32'd0);

    // Three words streamed with m_tready high.
    src_q = '{8'h11, 8'h22, 8'h33};
    got_q.delete();
    peak = 0;
    step(1'b1, 1'b0);
    chk("s3_c0_rinc", 32'(obs_rinc), 32'd1);
    chk("s3_c0_valid", 32'(obs_valid), 32'd0);
    step(1'b1, 1'b0);
    chk("s3_c1_rinc", 32'(obs_rinc), 32'd1);
    chk("s3_c1_tdata", 32'(obs_tdata), 32'h11);
    if (int'(obs_count) > peak) peak = int'(obs_count);
    step(1'b1, 1'b0);
    chk("s3_c2_rinc", 32'(obs_rinc), 32'd1);
    chk("s3_c2_tdata", 32'(obs_tdata), 32'h22);
    if (int'(obs_count) > peak) peak = int'(obs_count);
    step(1'b1, 1'b0);
    chk("s3_c3_rinc", 32'(obs_rinc), 32'd0);
    chk("s3_c3_tdata", 32'(obs_tdata), 32'h33);
    if (int'(obs_count) > peak) peak = int'(obs_count);
    step(1'b1, 1'b0);
    chk("s3_c4_valid", 32'(obs_valid), 32'd0);
    chk("s3_peak_count", 32'(peak), 32'd1);

    // Five words with m_tready low: only two are popped, head held stable.
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    got_q.delete();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      if (obs_rinc) pulses++;
      if (i >= 2) chk("s5_hold_tdata", 32'(obs_tdata), 32'h01);
    end
    chk("s5_rinc_pulses", 32'(pulses), 32'd2);
    chk("s5_count", 32'(obs_count), 32'd2);
    for (int i = 0; i < 20 && got_q.size() < 5; i++) step(1'b1, 1'b0);
    chk("s5_drained", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("s5_order", 32'(got_q[i]), 32'(exp5[i]));

    // Simultaneous push and pop at count 1 replaces head.
    src_q = '{8'h5A, 8'hA5};
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("pp_count_before", 32'(obs_count), 32'd1);
    chk("pp_rinc", 32'(obs_rinc), 32'd1);
    step(1'b0, 1'b1);
    chk("pp_count_after", 32'(obs_count), 32'd1);
    chk("pp_tdata_after", 32'(obs_tdata), 32'hA5);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Reset asserted between edges while the buffer is full.
    src_q = '{8'hE1, 8'hE2, 8'hE3};
    repeat (3) step(1'b0, 1'b0);
    chk("rst_pre_count", 32'(obs_count), 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_count", 32'(count), 32'd0);
    chk("rst_async_valid", 32'(m_tvalid), 32'd0);
    chk("rst_async_rinc", 32'(rinc), 32'd0);
    out_q.delete();
    src_q.delete();
    repeat (2) step(1'b1, 1'b0);
    reset = 1'b0;
    src_q = '{8'hC1, 8'hC2, 8'hC3};
    got_q.delete();
    for (int i = 0; i < 20 && got_q.size() < 3; i++) step(1'b1, 1'b0);
    chk("rst_after_words", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("rst_after_order", 32'(got_q[i]), 32'(exp3[i]));

    // Random ready and FIFO gaps over 10000 words.
    got_q.delete();
    recv_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      w = 8'($urandom);
      src_q.push_back(w);
    end
    for (int c = 0; c < 60000 && recv_cnt < 10000; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    chk("rand_words_received", 32'(recv_cnt), 32'd10000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of output buffer entries; the only legal value is 2.
REQ-003 clk  input  1  single clock; connects to the same net as the FIFO read clock rclk.
REQ-004 reset  input  1  asynchronous, active-high reset; the FIFO read-side reset rrst_n is driven from ~reset by the integrator.
REQ-005 rdata  input  DSIZE  FIFO read data; valid in the same cycle whenever rempty is low.
REQ-006 rempty  input  1  FIFO empty flag, synchronous to clk.
REQ-007 rinc  output  1  FIFO pop strobe; one word is consumed per cycle in which rinc is high.
REQ-008 m_tvalid  output  1  downstream data valid.
REQ-009 m_tready  input  1  downstream ready.
REQ-010 m_tdata  output  DSIZE  downstream data.
REQ-011 count  output  2  number of words currently held in the output buffer (0..2).

Function
REQ-012 The output buffer SHALL be a 2-entry register FIFO (head, tail) with a 2-bit occupancy count.
REQ-013 rinc SHALL equal (!rempty && count < 2 && !reset).
- No combinational path from m_tready to rinc.
REQ-014 push = rinc; pop = m_tvalid && m_tready.
- count_next = count + push - pop, evaluated every clock edge.
REQ-015 m_tvalid SHALL equal (count != 0); m_tdata SHALL equal the head entry.
- Both are functions of registers only.
REQ-016 On push with count==0 or (count==1 && pop): rdata SHALL load into head.
REQ-017 On push with count==1 && !pop: rdata SHALL load into tail.
REQ-018 On pop with count==2: tail SHALL move to head in the same edge.
- A push is impossible at count==2 (REQ-013).
REQ-019 Words SHALL leave on m_tdata in exactly the order they were popped from the FIFO, with no loss or duplication.
REQ-020 Latency: a word with rempty low during cycle N is captured at the end of cycle N and appears with m_tvalid high in cycle N+1 when count was 0.
REQ-021 Throughput: with rempty low and m_tready high continuously, one word per cycle SHALL transfer in steady state, with count holding at 1.
REQ-022 With m_tready low, at most 2 words SHALL be popped; rinc then stays low until a pop frees space.
REQ-023 m_tdata and m_tvalid SHALL remain stable while m_tvalid is high and m_tready is low.
REQ-024 Simultaneous push and pop at count==1 SHALL keep count at 1 and replace head with the new word.
REQ-025 If rempty rises while count>0, buffered words SHALL still drain normally.

Reset
REQ-026 While reset is high, count SHALL be 0, m_tvalid 0 and rinc 0, asynchronously.
REQ-027 head and tail data registers SHALL NOT require reset.
- m_tdata is don't-care while m_tvalid is 0.
REQ-028 Reset asserted mid-operation SHALL discard buffered words immediately.
REQ-029 The first rinc after reset deassertion SHALL occur no earlier than the first clk edge at which reset is sampled low and rempty is low.

Verification
REQ-030 Reset, then rempty=1 for 10 cycles -> rinc=0, m_tvalid=0 and count=0 throughout.
REQ-031 FIFO holds 0x11,0x22,0x33 and m_tready=1 -> rinc high 3 consecutive cycles; m_tdata 0x11,0x22,0x33 on 3 consecutive cycles starting 1 cycle after the first rinc; count peaks at 1.
REQ-032 FIFO holds 5 words and m_tready=0 -> exactly 2 rinc pulses; count=2; m_tdata holds the first word stable; raising m_tready drains all 5 words in order.
REQ-033 Random m_tready toggling and random rempty gaps over 10000 words -> output sequence equals input sequence; count never exceeds 2; no rinc while rempty=1.
REQ-034 reset pulsed while count=2 -> count, m_tvalid and rinc drop to 0 without waiting for a clock edge; after release, new words stream correctly.
REQ-035 count==1 with simultaneous pop and push of 0xA5 -> next cycle count=1 and m_tdata=0xA5.
